// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: strobes one active-low column at a time, debounces the
// synchronised rows and latches a key code with sticky valid and overrun flags.
module keypad_scan #(
  parameter int SCAN_DIV = 62500,
  parameter int DEBOUNCE = 20
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  input  logic       rd_ack,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed,
  output logic       overrun
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD
  } state_t;

  state_t             state, state_n;
  logic [DIV_W-1:0]   div;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [1:0]         col, col_n;
  logic [3:0]         row_s1, rs;
  logic [3:0]         pat, pat_n;
  logic [3:0]         cand_code, cand_n;
  logic [3:0]         acc_code;
  logic [1:0]         cand_row;
  logic               sample, pressed, accept, release_key;

  assign sample  = (div == DIV_W'(SCAN_DIV - 1));
  assign pressed = (rs != 4'b1111);

  // Lowest-numbered active row wins when several rows are low at once.
  always_comb begin
    cand_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rs[i]) cand_row = 2'(i);
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    col_n       = col;
    pat_n       = pat;
    cand_n      = cand_code;
    acc_code    = cand_code;
    accept      = 1'b0;
    release_key = 1'b0;
    case (state)
      ST_SCAN: begin
        if (sample && pressed) begin
          pat_n    = rs;
          cand_n   = {cand_row, col};
          acc_code = {cand_row, col};
          if (DEBOUNCE == 1) begin
            accept  = 1'b1;
            cnt_n   = '0;
            state_n = ST_HELD;
          end else begin
            cnt_n   = CNT_W'(1);
            state_n = ST_DEBOUNCE;
          end
        end else if (sample) begin
          col_n = col + 2'd1;
        end
      end
      ST_DEBOUNCE: begin
        if (sample) begin
          if (rs == pat) begin
            if (cnt == CNT_W'(DEBOUNCE - 1)) begin
              accept  = 1'b1;
              cnt_n   = '0;
              state_n = ST_HELD;
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end else begin
            cnt_n   = '0;
            col_n   = col + 2'd1;
            state_n = ST_SCAN;
          end
        end
      end
      ST_HELD: begin
        // Any pressed pattern restarts the release count; pattern changes are ignored.
        if (sample) begin
          if (!pressed) begin
            if (cnt == CNT_W'(DEBOUNCE - 1)) begin
              release_key = 1'b1;
              cnt_n       = '0;
              col_n       = col + 2'd1;
              state_n     = ST_SCAN;
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end else begin
            cnt_n = '0;
          end
        end
      end
      default: state_n = ST_SCAN;
    endcase
  end

  // NOTE: non-blocking assignments keep row_s1 -> rs a true two-stage shift.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state       <= ST_SCAN;
      div         <= '0;
      cnt         <= '0;
      col         <= 2'd0;
      col_out     <= 4'b1110;
      row_s1      <= 4'b1111;
      rs          <= 4'b1111;
      pat         <= 4'b1111;
      cand_code   <= 4'd0;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      key_pressed <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      row_s1    <= row_in;
      rs        <= row_s1;
      div       <= sample ? '0 : div + DIV_W'(1);
      state     <= state_n;
      cnt       <= cnt_n;
      col       <= col_n;
      col_out   <= ~(4'b0001 << col_n);
      pat       <= pat_n;
      cand_code <= cand_n;
      if (accept) key_code <= acc_code;
      // An accept coinciding with rd_ack sets valid and does not count as overrun.
      key_valid <= accept | (key_valid & ~rd_ack);
      overrun   <= ~rd_ack & (overrun | (accept & key_valid));
      if (accept)           key_pressed <= 1'b1;
      else if (release_key) key_pressed <= 1'b0;
    end
  end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Hardware scanner for the 4x4 matrix keypad on the ioa header. It replaces software column strobing behind the keypad CSR.
- Drives one column low at a time, synchronises and debounces the row inputs, and latches a 4-bit key code with a sticky valid flag.
- The CPU reads the flag and code through the keypad read mux and clears the flag with a read-acknowledge pulse.
- Runs on the 62.5 MHz CPU clock.

Parameters:
- SCAN_DIV, 62500: clock cycles per column period, i.e. per row sample (1 ms at 62.5 MHz). Must be >= 4.
- DEBOUNCE, 20: number of consecutive identical row samples needed to accept a press or a release. Must be >= 1.

Ports:
- clk  input  1  system clock, 62.5 MHz.
- reset_  input  1  asynchronous, active-low reset.
- row_in  input  4  keypad row lines (ioa_hi). Active-low, pulled up externally, asynchronous to clk.
- col_out  output  4  keypad column drive (ioa_lo). Active-low; exactly one bit is 0 at all times.
- rd_ack  input  1  one-cycle pulse from the CPU read decode; clears key_valid and overrun.
- key_code  output  4  last accepted key, equal to row_index*4 + col_index.
- key_valid  output  1  sticky flag: a new key has been accepted and not yet acknowledged.
- key_pressed  output  1  level: a debounced key is currently held.
- overrun  output  1  sticky flag: a key was accepted while key_valid was still 1.

Behaviour:
- Clock and reset: one clock, clk. reset_ is asynchronous and active-low; it clears everything immediately, including mid-debounce or mid-hold.
- Reset values:
  - col_out=4'b1110 (column 0 driven)
  - key_code=0, key_valid=0, key_pressed=0, overrun=0
  - state=SCAN; divider, debounce counter and column index all 0
  - synchroniser flops =4'b1111
- Row synchronisation: row_in passes through a 2-flop synchroniser; all decisions use the second flop (rs).
- Divider: counts 0..SCAN_DIV-1 and wraps. A "sample" occurs in the cycle where divider==SCAN_DIV-1. No decision is made outside a sample cycle.
- Row selection: cand = index of the lowest-numbered 0 bit in rs. "Pressed" means rs != 4'b1111.
- State SCAN:
  - At a sample with rs==4'b1111: column index increments mod 4 and col_out rotates to the next column on the same edge.
  - At a sample with rs pressed: store pat=rs and cand_code=cand*4+col, set cnt=1 and go to DEBOUNCE. The column does not advance.
  - If DEBOUNCE==1, skip DEBOUNCE and take the accept action on this same sample.
- State DEBOUNCE (column frozen):
  - At a sample with rs==pat: cnt increments. When cnt reaches DEBOUNCE, accept and go to HELD.
  - At a sample with rs!=pat: return to SCAN, cnt=0, and advance the column.
- Accept action (one edge):
  - key_code<=cand_code; key_valid<=1; key_pressed<=1.
  - overrun<=1 if key_valid was 1 and rd_ack is 0 in that cycle.
- State HELD (column frozen):
  - At a sample with rs==4'b1111: cnt increments. When cnt reaches DEBOUNCE: key_pressed<=0, go to SCAN, advance the column.
  - At a sample with rs pressed: cnt=0. Changes in the row pattern while held are ignored, so there is no second key and no rollover.
- rd_ack:
  - Clears key_valid and overrun on the next edge in any state.
  - If rd_ack coincides with an accept edge, the set wins: key_valid=1, and overrun is not set by that accept.
- Holding a key produces exactly one key_valid event. There is no auto-repeat.
- Latency:
  - key_valid rises on the edge of the DEBOUNCE-th matching sample, counting the detecting sample as 1.
  - The press must be visible in rs, i.e. the synchroniser's 2 cycles are added.

Test Plan (SCAN_DIV=4, DEBOUNCE=3 unless noted):
- Reset, idle rows=4'b1111 -> col_out cycles 1110, 1101, 1011, 0111, 1110, changing every 4 clocks; all flags stay 0; after 1000 cycles still no valid.
- Hold row 2 low only while col 1 is driven, stable -> accepted on the 3rd matching sample: key_code=9, key_valid=1, key_pressed=1, col_out frozen at 1101. Release -> key_pressed=0 after 3 idle samples, then scanning resumes at col 2.
- Bounce: row 0 low for 1 sample, high for 1, repeated 5 times on col 0 -> key_valid never asserts; scanning continues after each abort.
- Press key 5, no rd_ack, release, then press key 14 -> key_code=14, key_valid=1, overrun=1. Pulse rd_ack -> key_valid=0, overrun=0.
- rd_ack pulsed on the exact accept edge of a second key -> key_valid=1, overrun=0, key_code updated.
- Rows 1 and 3 low together on col 2 -> key_code=6 (lowest row wins). Assert reset_=0 mid-HELD -> all outputs at reset values immediately, col_out=1110.
